// File: rtl/pwm_clkgen_multi_if.sv
// Configuration port for pwm_clkgen_multi: one valid/ready write of
// period, high time and start phase to a selected channel.
interface pwm_clkgen_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_clkgen_multi.sv
// Multi-channel PWM / divided-clock generator with per-channel start delay and
// period-boundary shadowing of configuration updates on running channels.
module pwm_clkgen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_clkgen_multi_if.slave      cfg,
  input  logic [NUM_CH-1:0]      ch_en,
  output logic [NUM_CH-1:0]      clk_out,
  output logic [NUM_CH-1:0]      wrap_pulse,
  output logic [NUM_CH-1:0]      cfg_pending
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic cfg_ready_r;

  // cfg_ready rises on the first edge after reset release and stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b1;
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, dly_r, dly_s, p_m1_s;
    logic [CNT_W-1:0] act_p_r, act_h_r, act_d_r, act_p_s, act_h_s, act_d_s;
    logic [CNT_W-1:0] shd_p_r, shd_h_r, shd_d_r, shd_p_s, shd_h_s, shd_d_s;
    logic             pend_r, pend_s, out_r, out_s, wrap_r, wrap_s, wr_s;

    assign wr_s = cfg.cfg_valid && cfg_ready_r && (cfg.cfg_ch == CH_W'(g));

    // P = 0 behaves as P = 1: the wrap point is then cnt = 0
    assign p_m1_s = (act_p_r > ONE) ? (act_p_r - ONE) : ZERO;

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
        cnt_r   <= ZERO;
        dly_r   <= ZERO;
        act_p_r <= ZERO;
        act_h_r <= ZERO;
        act_d_r <= ZERO;
        shd_p_r <= ZERO;
        shd_h_r <= ZERO;
        shd_d_r <= ZERO;
        pend_r  <= 1'b0;
        out_r   <= 1'b0;
        wrap_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        dly_r   <= dly_s;
        act_p_r <= act_p_s;
        act_h_r <= act_h_s;
        act_d_r <= act_d_s;
        shd_p_r <= shd_p_s;
        shd_h_r <= shd_h_s;
        shd_d_r <= shd_d_s;
        pend_r  <= pend_s;
        out_r   <= out_s;
        wrap_r  <= wrap_s;
      end
    end

    // Next state, counters, config routing and registered waveform
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      dly_s   = dly_r;
      act_p_s = act_p_r;
      act_h_s = act_h_r;
      act_d_s = act_d_r;
      shd_p_s = shd_p_r;
      shd_h_s = shd_h_r;
      shd_d_s = shd_d_r;
      pend_s  = pend_r;
      out_s   = 1'b0;
      wrap_s  = 1'b0;
      if (!ch_en[g]) begin
        state_s = ST_IDLE;
        cnt_s   = ZERO;
        dly_s   = ZERO;
        pend_s  = 1'b0;
        // A same-edge write is newer than any pending shadow
        if (wr_s) begin
          act_p_s = cfg.cfg_period;
          act_h_s = cfg.cfg_high;
          act_d_s = cfg.cfg_phase;
        end else if (pend_r) begin
          act_p_s = shd_p_r;
          act_h_s = shd_h_r;
          act_d_s = shd_d_r;
        end else begin
          act_p_s = act_p_r;
        end
      end else begin
        case (state_r)
          ST_IDLE, ST_DELAY: begin
            if (wr_s) begin
              act_p_s = cfg.cfg_period;
              act_h_s = cfg.cfg_high;
              act_d_s = cfg.cfg_phase;
            end else begin
              act_p_s = act_p_r;
            end
            cnt_s = ZERO;
            if (state_r == ST_IDLE) begin
              if (act_d_s == ZERO) begin
                state_s = ST_RUN;
                out_s   = (act_h_s != ZERO);
              end else begin
                state_s = ST_DELAY;
                dly_s   = act_d_s;
              end
            end else if (dly_r <= ONE) begin
              state_s = ST_RUN;
              dly_s   = ZERO;
              out_s   = (act_h_s != ZERO);
            end else begin
              dly_s = dly_r - ONE;
            end
          end
          ST_RUN: begin
            if (cnt_r >= p_m1_s) begin
              cnt_s  = ZERO;
              wrap_s = 1'b1;
              if (pend_r) begin
                act_p_s = shd_p_r;
                act_h_s = shd_h_r;
                act_d_s = shd_d_r;
                pend_s  = 1'b0;
              end else begin
                pend_s = 1'b0;
              end
            end else begin
              cnt_s = cnt_r + ONE;
            end
            // A write on the wrap edge waits for the following boundary
            if (wr_s) begin
              shd_p_s = cfg.cfg_period;
              shd_h_s = cfg.cfg_high;
              shd_d_s = cfg.cfg_phase;
              pend_s  = 1'b1;
            end else begin
              shd_p_s = shd_p_r;
            end
            out_s = (cnt_s < act_h_s);
          end
          default: begin
            state_s = ST_IDLE;
            cnt_s   = ZERO;
            dly_s   = ZERO;
          end
        endcase
      end
    end

    assign clk_out[g]     = out_r;
    assign wrap_pulse[g]  = wrap_r;
    assign cfg_pending[g] = pend_r;
  end

endmodule
